// File: rtl/synth_pkg.sv
// Register-map constants and shared types for the synth register port.
package synth_pkg;
  localparam int         REG_VOICE_SHIFT = 12;
  localparam int         REG_OP_SHIFT    = 9;
  localparam logic [2:0] REG_OP_KEYON    = 3'd0;
  localparam int         VOICE_W         = 4;
  localparam int         NOTE_W          = 7;

  typedef logic [NOTE_W-1:0] NoteId_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_KEYOFF,
    ST_PHASE,
    ST_KEYON,
    ST_ALLOFF
  } state_e;

  // The register map numbers voices from 1, so voice 15 wraps to field value 0.
  function automatic logic [15:0] reg_addr(input logic [VOICE_W-1:0] voice, input logic [2:0] op);
    logic [VOICE_W-1:0] v;
    v = voice + VOICE_W'(1);
    return (16'(v) << REG_VOICE_SHIFT) | (16'(op) << REG_OP_SHIFT);
  endfunction
endpackage

// File: rtl/voice_select.sv
// Combinational voice search: note match, lowest free voice, or oldest voice to steal.
module voice_select
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int AGE_WIDTH  = 4
) (
  input  logic [NUM_VOICES-1:0]           i_Active,
  input  logic [NUM_VOICES*NOTE_W-1:0]    i_NoteIds,
  input  logic [NUM_VOICES*AGE_WIDTH-1:0] i_Ages,
  input  logic                            i_NoteOn,
  input  logic [NOTE_W-1:0]               i_NoteId,
  output logic [VOICE_W-1:0]              o_Target,
  output logic                            o_Hit,
  output logic                            o_Steal
);
  logic                 match_found;
  logic [VOICE_W-1:0]   match_idx;
  logic                 free_found;
  logic [VOICE_W-1:0]   free_idx;
  logic [VOICE_W-1:0]   old_idx;
  logic [AGE_WIDTH-1:0] old_age;

  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    // Descending scan so the lowest matching index is the last one written.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (i_Active[i] && (i_NoteIds[i*NOTE_W +: NOTE_W] == i_NoteId)) begin
        match_found = 1'b1;
        match_idx   = VOICE_W'(i);
      end
      if (!i_Active[i]) begin
        free_found = 1'b1;
        free_idx   = VOICE_W'(i);
      end
    end
    // Strict compare keeps ties on the lowest index.
    old_idx = '0;
    old_age = i_Ages[AGE_WIDTH-1:0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (i_Ages[i*AGE_WIDTH +: AGE_WIDTH] > old_age) begin
        old_age = i_Ages[i*AGE_WIDTH +: AGE_WIDTH];
        old_idx = VOICE_W'(i);
      end
    end
    o_Hit   = match_found;
    o_Steal = i_NoteOn && !match_found && !free_found;
    if (match_found)
      o_Target = match_idx;
    else if (free_found)
      o_Target = free_idx;
    else
      o_Target = old_idx;
  end
endmodule

// File: rtl/voice_allocator.sv
// Note scheduler: picks a voice per note request and emits the KeyOn/PhaseStep
// register-write sequence that configures it.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES    = 16,
  parameter int NUM_OPERATORS = 6,
  parameter int AGE_WIDTH     = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_NoteValid,
  output logic        o_NoteReady,
  input  logic        i_NoteOn,
  input  logic [6:0]  i_NoteId,
  input  logic [15:0] i_PhaseStep,
  input  logic        i_AllOff,
  output logic [15:0] o_RegisterNumber,
  output logic [15:0] o_RegisterValue,
  output logic        o_RegisterWriteEnable,
  output logic        o_Busy
);
  state_e                          state_q, state_d;
  logic [NUM_VOICES-1:0]           active_q, active_d;
  logic [NUM_VOICES*NOTE_W-1:0]    note_q, note_d;
  logic [NUM_VOICES*AGE_WIDTH-1:0] age_q, age_d;
  logic                            req_on_q, req_on_d;
  NoteId_t                         req_note_q, req_note_d;
  logic [15:0]                     step_q, step_d;
  logic [VOICE_W-1:0]              target_q, target_d;
  logic [2:0]                      op_q, op_d;
  logic [VOICE_W-1:0]              cnt_q, cnt_d;
  logic                            we_q, we_d;
  logic [15:0]                     num_q, num_d;
  logic [15:0]                     val_q, val_d;
  logic                            busy_q, busy_d;

  logic [VOICE_W-1:0] sel_target;
  logic               sel_hit;
  logic               sel_steal;

  voice_select #(
    .NUM_VOICES(NUM_VOICES),
    .AGE_WIDTH (AGE_WIDTH)
  ) u_select (
    .i_Active (active_q),
    .i_NoteIds(note_q),
    .i_Ages   (age_q),
    .i_NoteOn (req_on_q),
    .i_NoteId (req_note_q),
    .o_Target (sel_target),
    .o_Hit    (sel_hit),
    .o_Steal  (sel_steal)
  );

  assign o_NoteReady           = (state_q == ST_IDLE) && !i_AllOff && !i_Reset;
  assign o_RegisterWriteEnable = we_q;
  assign o_RegisterNumber      = num_q;
  assign o_RegisterValue       = val_q;
  assign o_Busy                = busy_q;

  // The output registers are loaded with the first write of the state being
  // entered, so each write is on the ports while its state is current.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    note_d     = note_q;
    age_d      = age_q;
    req_on_d   = req_on_q;
    req_note_d = req_note_q;
    step_d     = step_q;
    target_d   = target_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    we_d       = 1'b0;
    num_d      = num_q;
    val_d      = val_q;
    case (state_q)
      ST_IDLE: begin
        if (i_AllOff) begin
          state_d = ST_ALLOFF;
          cnt_d   = '0;
          we_d    = 1'b1;
          num_d   = reg_addr('0, REG_OP_KEYON);
          val_d   = 16'h0000;
        end else if (i_NoteValid) begin
          state_d    = ST_SEARCH;
          req_on_d   = i_NoteOn;
          req_note_d = i_NoteId;
          step_d     = i_PhaseStep;
        end
      end
      ST_SEARCH: begin
        target_d = sel_target;
        if (sel_hit || sel_steal) begin
          state_d = ST_KEYOFF;
          we_d    = 1'b1;
          num_d   = reg_addr(sel_target, REG_OP_KEYON);
          val_d   = 16'h0000;
        end else if (req_on_q) begin
          state_d = ST_PHASE;
          op_d    = 3'd1;
          we_d    = 1'b1;
          num_d   = reg_addr(sel_target, 3'd1);
          val_d   = step_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_KEYOFF: begin
        if (req_on_q) begin
          state_d = ST_PHASE;
          op_d    = 3'd1;
          we_d    = 1'b1;
          num_d   = reg_addr(target_q, 3'd1);
          val_d   = step_q;
        end else begin
          state_d                                   = ST_IDLE;
          active_d[target_q]                        = 1'b0;
          age_d[target_q*AGE_WIDTH +: AGE_WIDTH]    = '0;
        end
      end
      ST_PHASE: begin
        we_d = 1'b1;
        if (op_q == 3'(NUM_OPERATORS)) begin
          state_d = ST_KEYON;
          num_d   = reg_addr(target_q, REG_OP_KEYON);
          val_d   = 16'h0001;
        end else begin
          op_d  = op_q + 3'd1;
          num_d = reg_addr(target_q, op_q + 3'd1);
          val_d = step_q;
        end
      end
      ST_KEYON: begin
        state_d = ST_IDLE;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (VOICE_W'(i) == target_q) begin
            active_d[i]                     = 1'b1;
            note_d[i*NOTE_W +: NOTE_W]      = req_note_q;
            age_d[i*AGE_WIDTH +: AGE_WIDTH] = '0;
          end else if (active_q[i] && (age_q[i*AGE_WIDTH +: AGE_WIDTH] != {AGE_WIDTH{1'b1}})) begin
            age_d[i*AGE_WIDTH +: AGE_WIDTH] = age_q[i*AGE_WIDTH +: AGE_WIDTH] + AGE_WIDTH'(1);
          end
        end
      end
      ST_ALLOFF: begin
        active_d[cnt_q]                     = 1'b0;
        age_d[cnt_q*AGE_WIDTH +: AGE_WIDTH] = '0;
        if (cnt_q == VOICE_W'(NUM_VOICES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + VOICE_W'(1);
          we_d  = 1'b1;
          num_d = reg_addr(cnt_q + VOICE_W'(1), REG_OP_KEYON);
          val_d = 16'h0000;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      active_q   <= '0;
      note_q     <= '0;
      age_q      <= '0;
      req_on_q   <= 1'b0;
      req_note_q <= '0;
      step_q     <= '0;
      target_q   <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      num_q      <= '0;
      val_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      note_q     <= note_d;
      age_q      <= age_d;
      req_on_q   <= req_on_d;
      req_note_q <= req_note_d;
      step_q     <= step_d;
      target_q   <= target_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      num_q      <= num_d;
      val_q      <= val_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: table of note requests with hand-computed
// write sequences, plus reset and all-off corner sequences.
module tb_voice_allocator;
  logic        clk = 1'b0;
  logic        rst;
  logic        nv;
  logic        non;
  logic        alloff;
  logic [6:0]  nid;
  logic [15:0] pstep;
  logic        ready;
  logic        we;
  logic        busy;
  logic [15:0] rnum;
  logic [15:0] rval;

  always #5 clk = ~clk;

  voice_allocator dut (
    .i_Clock              (clk),
    .i_Reset              (rst),
    .i_NoteValid          (nv),
    .o_NoteReady          (ready),
    .i_NoteOn             (non),
    .i_NoteId             (nid),
    .i_PhaseStep          (pstep),
    .i_AllOff             (alloff),
    .o_RegisterNumber     (rnum),
    .o_RegisterValue      (rval),
    .o_RegisterWriteEnable(we),
    .o_Busy               (busy)
  );

  typedef struct {
    bit          is_alloff;
    bit          with_note;
    bit          on;
    logic [6:0]  id;
    logic [15:0] step;
    int          n_writes;
    logic [15:0] key_addr;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit ao, bit wn, bit on, int id, logic [15:0] step, int n, logic [15:0] ka);
    vec_t v;
    v.is_alloff = ao;
    v.with_note = wn;
    v.on        = on;
    v.id        = 7'(id);
    v.step      = step;
    v.n_writes  = n;
    v.key_addr  = ka;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int idx);
    logic [15:0] ga[$];
    logic [15:0] gv[$];
    int          gc[$];
    logic [15:0] ea[$];
    logic [15:0] ev[$];
    int          first;
    int          n;
    @(negedge clk);
    nv     = v.is_alloff ? v.with_note : 1'b1;
    non    = v.on;
    nid    = v.id;
    pstep  = v.step;
    alloff = v.is_alloff;
    #1;
    check($sformatf("row%0d_ready_c0", idx), ready, v.is_alloff ? 0 : 1);
    @(negedge clk);
    nv     = 1'b0;
    alloff = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge clk);
      if (we) begin
        ga.push_back(rnum);
        gv.push_back(rval);
        gc.push_back(c);
      end
      if (c == 2 && v.n_writes == 0 && !v.is_alloff)
        check($sformatf("row%0d_ready_c2", idx), ready, 1);
    end
    if (v.is_alloff) begin
      first = 1;
      for (int k = 0; k < 16; k++) begin
        ea.push_back(16'((k + 1) % 16) << 12);
        ev.push_back(16'h0000);
      end
    end else begin
      first = 2;
      if (v.n_writes == 1 || v.n_writes == 8) begin
        ea.push_back(v.key_addr);
        ev.push_back(16'h0000);
      end
      if (v.n_writes >= 7) begin
        for (int op = 1; op <= 6; op++) begin
          ea.push_back(v.key_addr + 16'(op * 16'h0200));
          ev.push_back(v.step);
        end
        ea.push_back(v.key_addr);
        ev.push_back(16'h0001);
      end
    end
    check($sformatf("row%0d_nwrites", idx), ga.size(), ea.size());
    n = (ga.size() < ea.size()) ? ga.size() : ea.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("row%0d_w%0d_addr", idx, k), ga[k], ea[k]);
      check($sformatf("row%0d_w%0d_data", idx, k), gv[k], ev[k]);
      check($sformatf("row%0d_w%0d_cycle", idx, k), gc[k], first + k);
    end
    check($sformatf("row%0d_ready_end", idx), ready, 1);
    check($sformatf("row%0d_busy_end", idx), busy, 0);
    $display("row %0d: alloff=%0d on=%0d id=%0d writes=%0d (expected %0d)",
             idx, v.is_alloff, v.on, v.id, ga.size(), ea.size());
  endtask

  initial begin
    bit found;
    int nw;

    // Three notes, all-off (with a colliding note request), then basic on/retrigger/off.
    tbl.push_back(mk(0, 0, 1, 10, 16'h1111, 7, 16'h1000));
    tbl.push_back(mk(0, 0, 1, 11, 16'h2222, 7, 16'h2000));
    tbl.push_back(mk(0, 0, 1, 12, 16'h3333, 7, 16'h3000));
    tbl.push_back(mk(1, 1, 1, 13, 16'h4444, 16, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 11, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 60, 16'h1234, 7, 16'h1000));
    tbl.push_back(mk(0, 0, 1, 60, 16'h4321, 8, 16'h1000));
    tbl.push_back(mk(0, 0, 0, 60, 16'h0000, 1, 16'h1000));
    tbl.push_back(mk(0, 0, 0, 99, 16'h0000, 0, 16'h0000));
    // Fill all 16 voices; voice 15 encodes as field 0.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 0, 1, 40 + i, 16'h0100 + 16'(i), 7, 16'((i + 1) % 16) << 12));
    tbl.push_back(mk(0, 0, 1, 70, 16'hABCD, 8, 16'h1000));
    tbl.push_back(mk(0, 0, 1, 71, 16'h5555, 8, 16'h2000));
    tbl.push_back(mk(0, 0, 0, 55, 16'h0000, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 80, 16'h0F0F, 7, 16'h0000));
    // Voices 2 and 3 both saturate at age 15: tie goes to voice 2.
    tbl.push_back(mk(0, 0, 1, 41, 16'h7777, 8, 16'h3000));
    tbl.push_back(mk(0, 0, 1, 80, 16'h0101, 8, 16'h0000));

    rst = 1'b1; nv = 1'b0; non = 1'b0; nid = '0; pstep = '0; alloff = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_we", we, 0);
    check("reset_num", rnum, 0);
    check("reset_val", rval, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", ready, 0);
    rst = 1'b0;
    #1;
    check("reset_ready_after", ready, 1);
    $display("reset: we=%0d num=%0h val=%0h busy=%0d ready=%0d", we, rnum, rval, busy, ready);

    for (int r = 0; r < tbl.size(); r++)
      apply_vec(tbl[r], r);

    // Reset in the middle of the PHASE writes.
    @(negedge clk);
    nv = 1'b1; non = 1'b1; nid = 7'd60; pstep = 16'h2468;
    #1;
    check("midrst_ready_c0", ready, 1);
    @(negedge clk);
    nv = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (we && rnum[11:9] == 3'd3) found = 1'b1;
      else @(negedge clk);
    end
    check("midrst_saw_op3", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_we", we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready_in_reset", ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", ready, 1);
    nw = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (we) nw++;
    end
    check("midrst_no_writes", nw, 0);
    $display("midrst: op3 seen=%0d writes after reset=%0d", found, nw);

    // Voice table was cleared: lowest voice is free and old notes are gone.
    apply_vec(mk(0, 0, 1, 61, 16'h0F0A, 7, 16'h1000), 100);
    apply_vec(mk(0, 0, 0, 70, 16'h0000, 0, 16'h0000), 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Note-level scheduler in front of the synth register port.
- Accepts note-on/note-off requests and picks a voice: retrigger, lowest free, or steal the oldest.
- Emits the register-write sequence (KeyOn, 6 operator PhaseSteps) that configures the chosen voice.
- Sits between the host command decoder and the synth's i_RegisterNumber/i_RegisterValue/i_RegisterWriteEnable inputs.

Parameters:
NUM_VOICES, 16, voices managed. Fixed by the register map; other values unsupported.
NUM_OPERATORS, 6, operators per voice.
AGE_WIDTH, 4, width of the per-voice saturating age counter.

Ports:
i_Clock  in  1  clock
i_Reset  in  1  synchronous, active-high reset
i_NoteValid  in  1  request valid
o_NoteReady  out  1  request accepted when valid&ready
i_NoteOn  in  1  1=note-on, 0=note-off
i_NoteId  in  7  note number
i_PhaseStep  in  16  phase step written to all operators on note-on
i_AllOff  in  1  pulse: key-off every voice
o_RegisterNumber  out  16  register address to synth
o_RegisterValue  out  16  register data to synth
o_RegisterWriteEnable  out  1  one-cycle write strobe
o_Busy  out  1  sequence in progress

Behaviour:
- Address encoding: {V[3:0], op[2:0], 9'h000}, where V=(voice index+1) mod 16, so voice 15 encodes as 4'h0.
  - op=0 is KeyOn, value bit 0.
  - op=1..6 is the operator PhaseStep.
- Per-voice state: Active, NoteId[6:0], Age[AGE_WIDTH-1:0]. After reset all are 0/inactive.
- Reset values: o_RegisterWriteEnable=0, o_RegisterNumber=0, o_RegisterValue=0, o_Busy=0, state IDLE.
  - o_NoteReady is 0 during reset and 1 in the first IDLE cycle after it.
- Reset mid-sequence aborts immediately. No further writes are issued and voice state clears.
- o_NoteReady=1 only in IDLE with i_AllOff low. i_AllOff takes priority over a same-cycle i_NoteValid; that note is not accepted.
- States:
  - IDLE: on valid&ready, latch the request and go to SEARCH. On i_AllOff, go to ALLOFF.
  - SEARCH (1 cycle): select target voice T.
    - Note-on, priority order:
      (a) active voice with NoteId==i_NoteId (retrigger);
      (b) lowest-index inactive voice;
      (c) active voice with maximum Age, ties to the lowest index (steal).
      - (a) or (c) goes to KEYOFF; (b) goes to PHASE.
    - Note-off: lowest-index active voice with matching NoteId.
      - Found: go to KEYOFF.
      - None: back to IDLE with no writes.
  - KEYOFF: write KeyOn(T)=0.
    - Note-off: clear Active[T], go to IDLE.
    - Note-on: go to PHASE.
  - PHASE: op counter 1..6, one write per cycle of PhaseStep(T,op)=latched i_PhaseStep. After op 6, go to KEYON.
  - KEYON: write KeyOn(T)=1.
    - Set Active[T]=1, NoteId[T]=note, Age[T]=0.
    - Every other active voice's Age increments, saturating at 2^AGE_WIDTH-1.
    - Go to IDLE.
  - ALLOFF: write KeyOn=0 to voices 0..15, one per cycle, clearing Active. Go to IDLE.
- Outputs are registered.
  - A write launched in state S appears on the ports the cycle after S is entered.
  - Writes are strictly one per cycle with no gaps inside a sequence.
- Latency from the accept cycle (cycle 0):
  - Free-voice note-on: writes on cycles 2..8 (7 writes).
  - Retrigger/steal: cycles 2..9 (8 writes).
  - Note-off hit: 1 write on cycle 2.
- o_Busy=1 from the cycle after accept until the cycle after the last write.
- Inactive voices' Age is held at 0.

Decomposition:
- Shared package synth_pkg (alongside core.svh types):
  - REG_VOICE_SHIFT=12, REG_OP_SHIFT=9, REG_OP_KEYON=0;
  - function reg_addr(voice, op) applying the (v+1) mod 16 mapping;
  - NoteId_t typedef.
- One sub-module, voice_select: combinational search over the voice table, returning T, hit and steal flags.

Test Plan:
- Reset, then note-on id=60 step=16'h1234 -> writes 16'h1200..16'h1C00 step 0x200 data 0x1234, then 16'h1000 data 1, on cycles 2..8; voice 0 active.
- Fill 16 notes (ids 40..55), then note-on id=70 -> steals voice 0 (oldest): KeyOn 0 to 16'h1000, 6 PhaseSteps, KeyOn 1; voice 15 writes use address 16'h0000.
- Note-on 60 twice -> second is a retrigger on the same voice with an 8-write sequence; no other voice changes.
- Note-off 60 -> single write 16'h1000 data 0; note-off 99 (absent) -> no writes, ready again on cycle 2.
- i_AllOff while idle with 3 active voices -> 16 consecutive KeyOn=0 writes, voices 0..15; all inactive afterwards.
- Assert i_Reset during PHASE op 3 -> write enable low from the next cycle, no further writes, ready 1 after reset deasserts.
